// File: rtl/novacore_cbus_pkg.sv
// Shared field positions, opcodes, status bit map and command record for the
// NovaCORE c_bus command decoder.
package novacore_cbus_pkg;

  localparam int CBUS_W      = 28;
  localparam int TOGGLE_BIT  = 27;
  localparam int OP_MSB      = 26;
  localparam int OP_LSB      = 24;
  localparam int MASK_MSB    = 23;
  localparam int MASK_LSB    = 20;
  localparam int PAYLOAD_MSB = 19;
  localparam int PAYLOAD_LSB = 0;

  localparam logic [2:0] OP_NOP        = 3'd0;
  localparam logic [2:0] OP_LOAD       = 3'd1;
  localparam logic [2:0] OP_START      = 3'd2;
  localparam logic [2:0] OP_STOP       = 3'd3;
  localparam logic [2:0] OP_READ       = 3'd4;
  localparam logic [2:0] OP_WRITE      = 3'd5;
  localparam logic [2:0] OP_SYNC       = 3'd6;
  localparam logic [2:0] OP_CLR_STATUS = 3'd7;

  localparam int ST_ACK     = 0;
  localparam int ST_LVL_LSB = 1;
  localparam int ST_LVL_W   = 5;
  localparam int ST_OVF     = 6;
  localparam int ST_BADMASK = 7;

  typedef struct packed {
    logic [OP_MSB-OP_LSB:0]           op;
    logic [MASK_MSB-MASK_LSB:0]       mask;
    logic [PAYLOAD_MSB-PAYLOAD_LSB:0] payload;
  } cmd_t;

  function automatic cmd_t unpack_cmd(input logic [CBUS_W-1:0] w);
    unpack_cmd = '{op:      w[OP_MSB:OP_LSB],
                   mask:    w[MASK_MSB:MASK_LSB],
                   payload: w[PAYLOAD_MSB:PAYLOAD_LSB]};
  endfunction

endpackage

// File: rtl/novacore_cbus_cmd_fifo.sv
// Small synchronous FIFO; the head word is read straight from the storage
// registers so downstream sees registered data with no path from pop.
module novacore_cbus_cmd_fifo #(
  parameter int WIDTH = 27,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/novacore_cbus_cmd_decoder.sv
// Turns host toggle events on the c_bus PIO word into queued NovaCORE commands.
// Define NOVACORE_CBUS_SYNC_EN to pass c_bus through a 2-flop synchronizer.
module novacore_cbus_cmd_decoder
  import novacore_cbus_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int PAYLOAD_W  = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [27:0]          c_bus,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [2:0]           cmd_op,
  output logic [NUM_CORES-1:0] cmd_core_mask,
  output logic [PAYLOAD_W-1:0] cmd_payload,
  output logic [31:0]          status
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [CBUS_W-1:0] cbus_d;

`ifdef NOVACORE_CBUS_SYNC_EN
  localparam logic [1:0] ARM_CYCLES = 2'd3;
  logic [CBUS_W-1:0] sync1, sync2;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= c_bus;
      sync2 <= sync1;
    end
  end
  assign cbus_d = sync2;
`else
  localparam logic [1:0] ARM_CYCLES = 2'd1;
  assign cbus_d = c_bus;
`endif

  logic [1:0] arm_cnt;
  logic       armed, prev_tgl, tgl, ev;
  logic       ack, ovf, bad_mask;
  logic       is_clr, is_bad, push, pop;
  logic       full, empty;
  logic [LW-1:0] level;
  cmd_t       in_cmd, head;

  // Arming waits until the detector input carries real post-reset data.
  assign armed  = (arm_cnt == ARM_CYCLES);
  assign tgl    = cbus_d[TOGGLE_BIT];
  assign in_cmd = unpack_cmd(cbus_d);
  assign ev     = armed && (tgl != prev_tgl);
  assign is_clr = (in_cmd.op == OP_CLR_STATUS);
  assign is_bad = !is_clr && (in_cmd.mask == '0);
  assign push   = ev && !is_clr && !is_bad;
  assign pop    = cmd_valid && cmd_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arm_cnt  <= '0;
      prev_tgl <= 1'b0;
      ack      <= 1'b0;
      ovf      <= 1'b0;
      bad_mask <= 1'b0;
    end else begin
      if (!armed) arm_cnt <= arm_cnt + 1'b1;
      prev_tgl <= tgl;
      if (ev) ack <= tgl;
      if (ev && is_clr) begin
        ovf      <= 1'b0;
        bad_mask <= 1'b0;
      end
      if (ev && is_bad) bad_mask <= 1'b1;
      if (push && full && !pop) ovf <= 1'b1;
    end
  end

  novacore_cbus_cmd_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (push),
    .pop   (pop),
    .din   (in_cmd),
    .dout  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  assign cmd_valid     = !empty;
  assign cmd_op        = head.op;
  assign cmd_core_mask = head.mask;
  assign cmd_payload   = head.payload;

  always_comb begin
    status                          = '0;
    status[ST_ACK]                  = ack;
    status[ST_LVL_LSB +: ST_LVL_W]  = ST_LVL_W'(level);
    status[ST_OVF]                  = ovf;
    status[ST_BADMASK]              = bad_mask;
  end

endmodule

// File: tb/tb_novacore_cbus_cmd_decoder.sv
// Directed plus random stimulus for the c_bus command decoder, checked against
// a queue-based reference model of the host/FIFO behaviour.
module tb_novacore_cbus_cmd_decoder;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [27:0] c_bus;
  logic        cmd_ready;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic [3:0]  cmd_core_mask;
  logic [19:0] cmd_payload;
  logic [31:0] status;

  int checks = 0;
  int errors = 0;

  logic        m_armed, m_prev, m_ack, m_ovf, m_bad;
  logic [26:0] m_q[$];

  novacore_cbus_cmd_decoder #(.NUM_CORES(4), .PAYLOAD_W(20), .FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .c_bus         (c_bus),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_core_mask (cmd_core_mask),
    .cmd_payload   (cmd_payload),
    .status        (status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_armed = 1'b0; m_prev = 1'b0; m_ack = 1'b0; m_ovf = 1'b0; m_bad = 1'b0;
    m_q.delete();
  endtask

  task automatic compare();
    chk("cmd_valid", 32'(cmd_valid), 32'(m_q.size() > 0));
    chk("status", status, {24'b0, m_bad, m_ovf, 5'(m_q.size()), m_ack});
    if (m_q.size() > 0) chk("head", 32'({cmd_op, cmd_core_mask, cmd_payload}), 32'(m_q[0]));
  endtask

  // One clock: model the host-visible effect of the current inputs, then compare.
  task automatic tick();
    logic        pop, ev;
    logic [27:0] w;
    w   = c_bus;
    pop = (m_q.size() > 0) && cmd_ready;
    ev  = m_armed && (w[27] != m_prev);
    @(posedge clk);
    if (pop) void'(m_q.pop_front());
    if (ev) begin
      m_ack = w[27];
      if (w[26:24] == 3'd7) begin m_ovf = 1'b0; m_bad = 1'b0; end
      else if (w[23:20] == 4'd0) m_bad = 1'b1;
      else if (m_q.size() < DEPTH) m_q.push_back(w[26:0]);
      else m_ovf = 1'b1;
    end
    m_prev  = w[27];
    m_armed = 1'b1;
    #1 compare();
  endtask

  task automatic write(input logic [2:0] op, input logic [3:0] mask, input logic [19:0] pl);
    c_bus = {~c_bus[27], op, mask, pl};
    tick();
  endtask

  initial begin
    logic [19:0] held;
    reset = 1'b1; c_bus = 28'h800_0000; cmd_ready = 1'b0;
    model_reset();
    #12;
    chk("rst_valid", 32'(cmd_valid), 0);
    chk("rst_status", status, 0);
    chk("rst_fields", 32'({cmd_op, cmd_core_mask, cmd_payload}), 0);
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("arm_quiet", status, 0);
    end

    // single command straight through
    cmd_ready = 1'b1;
    write(3'd1, 4'h3, 20'hABCDE);
    chk("t1_valid", 32'(cmd_valid), 1);
    chk("t1_op", 32'(cmd_op), 1);
    chk("t1_mask", 32'(cmd_core_mask), 32'h3);
    chk("t1_payload", 32'(cmd_payload), 32'hABCDE);
    chk("t1_ack", 32'(status[0]), 32'(c_bus[27]));
    tick();
    chk("t1_level", 32'(status[5:1]), 0);

    // overflow with the sink stalled
    cmd_ready = 1'b0;
    for (int i = 1; i <= 5; i++) write(3'd2, 4'h1, 20'(i));
    chk("ovf_level", 32'(status[5:1]), 4);
    chk("ovf_flag", 32'(status[6]), 1);
    held = cmd_payload;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold", 32'(cmd_payload), 32'(held));
    end
    cmd_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_order", 32'(cmd_payload), 32'(i));
      tick();
    end
    chk("drained", 32'(cmd_valid), 0);

    // push into a full FIFO on the same edge as a pop
    cmd_ready = 1'b0;
    write(3'd7, 4'h1, 20'h0);
    for (int i = 0; i < 4; i++) write(3'd3, 4'hF, 20'(i + 10));
    chk("full_level", 32'(status[5:1]), 4);
    cmd_ready = 1'b1;
    write(3'd4, 4'h2, 20'h77);
    chk("pushpop_level", 32'(status[5:1]), 4);
    chk("pushpop_ovf", 32'(status[6]), 0);
    repeat (5) tick();

    // bad mask, then status clear
    cmd_ready = 1'b0;
    write(3'd5, 4'h0, 20'h5);
    chk("bad_flag", 32'(status[7]), 1);
    chk("bad_novalid", 32'(cmd_valid), 0);
    write(3'd7, 4'h2, 20'h0);
    chk("clr_flags", 32'(status[7:6]), 0);
    chk("clr_novalid", 32'(cmd_valid), 0);
    chk("clr_ack", 32'(status[0]), 32'(c_bus[27]));

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cmd_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) != 0)
        c_bus = {~c_bus[27], 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                 20'($urandom)};
      tick();
    end

    // asynchronous reset with commands pending
    cmd_ready = 1'b1;
    repeat (6) tick();
    cmd_ready = 1'b0;
    for (int i = 0; i < 3; i++) write(3'd1, 4'h1, 20'(i + 100));
    chk("pre_rst_level", 32'(status[5:1]), 3);
    #2 reset = 1'b1;
    #1;
    chk("async_valid", 32'(cmd_valid), 0);
    chk("async_status", status, 0);
    model_reset();
    c_bus = {1'b1, 3'd1, 4'h1, 20'h9};
    @(posedge clk); #1 reset = 1'b0;
    tick();
    chk("rearm_valid", 32'(cmd_valid), 0);
    chk("rearm_status", status, 0);
    write(3'd1, 4'h8, 20'h9);
    chk("post_rst_valid", 32'(cmd_valid), 1);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
